acc_exec_unit: RTL and testbench
================================

# acc_exec_unit

Sequential execute controller that owns the 16-bit accumulator (ACC) and flag register and drives the combinational ALU in the datapath. It accepts one opcode plus operand per valid/ready handshake and raises exactly one ALU control strobe (C8..C21) for the required number of cycles. It then captures ALU_out/ALUflags into ACC/flags and pulses done. It is the sequencing end of the ALU control interface, sitting between the instruction decoder and the ALU.

## Interface
- MULDIV_WAIT, 3: cycles C15/C16 are held before capture, range 1..15. All other ALU ops hold 1 cycle.
- clk  in  1  system clock. All state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- op_valid  in  1  opcode/operand valid.
- op_ready  out  1  unit can accept; high only in IDLE.
- op_code  in  4  0 NOP, 1 CLR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHL, 7 SHR, 8 AND, 9 OR, 10 NOT, 11 LOAD, 12-15 illegal.
- op_operand  in  16  second operand (BR value, or LOAD data).
- C8, C9, C13, C15, C16, C17, C18, C19, C20, C21  out  1 each  registered ALU strobes (clear, add, sub, mul, div, shl, shr, and, or, not).
- ACC_out  out  16  accumulator register; drives ALU ACC_in.
- BR_out  out  16  latched operand; drives ALU BR_in.
- ALU_in  in  16  from ALU_out.
- ALUflags_in  in  4  from ALUflags, {ZF,CF,OF,SF}.
- flags_q  out  4  flag register, {ZF,CF,OF,SF}.
- done  out  1  one-cycle completion pulse.
- err_illegal  out  1  one-cycle pulse, coincident with done, for opcodes 12-15.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: op_ready=1. When op_valid is high, the handshake completes. The unit latches op_code and op_operand into BR_out, loads wait_cnt, and goes to EXEC.
- EXEC: exactly one strobe is high, mapped from the opcode. Strobes are one-hot and are all 0 in every other state.
  - wait_cnt = MULDIV_WAIT for MUL/DIV, otherwise 1. It decrements each EXEC cycle.
  - On the last EXEC cycle (wait_cnt==1), the edge captures ACC<=ALU_in and flags_q<=ALUflags_in, then the FSM goes to DONE.
- NOP drives no strobe. ALU pass-through is captured (ACC unchanged, flags recomputed).
- LOAD drives no strobe and bypasses the ALU: ACC<=op_operand, flags_q<={operand==0,0,0,operand[15]}.
- Illegal opcodes drive no strobe. ACC and flags_q are unchanged, and err_illegal is set with done.
- DIV by zero needs no special handling. The ALU result (FFFF, CF=1) is captured as-is.
- DONE: done=1 for one cycle, ACC_out/flags_q already show the new values, op_ready=0. Next state is IDLE.
- op_valid while op_ready=0 is ignored. The producer holds op_code/op_operand stable until accepted.

## Timing
- Reset (rst_n low at an edge, in any state, including mid-EXEC) gives after that edge:
  - state=IDLE, ACC_out=0000, BR_out=0000, flags_q=4'b1000;
  - all C*=0, done=0, err_illegal=0, op_ready=1;
  - the in-flight op is discarded and no done is produced.
- Acceptance edge T: strobe high from T+1 for N cycles (N=1 or MULDIV_WAIT). ACC updates at edge T+N and done is high in the cycle after T+N.
- Next acceptance is possible at edge T+N+2 at the earliest, since IDLE follows DONE.
- LOAD, NOP and illegal ops take the EXEC path with N=1 (no strobe), so latency is uniform.
- BR_out and ACC_out are stable for the whole EXEC window, giving the ALU N cycles to settle.
- Widths: 16-bit ACC and BR, 4-bit counter, no arithmetic in this block other than the counter decrement.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_NOP..OP_LOAD);
  - flag bit indices ZF=3, CF=2, OF=1, SF=0;
  - FLAGS_RST=4'b1000;
  - the state encoding.
- One sub-module, acc_op_decode: combinational opcode to {10-bit strobe vector, is_muldiv, is_load, is_illegal}. The FSM, counter and registers live in acc_exec_unit.

## Test plan
- Reset: hold rst_n=0 one cycle -> ACC_out=0000, flags_q=1000, all C*=0, op_ready=1, done=0.
- LOAD 0x7FFF, then ADD 0x0001 -> C9 high exactly 1 cycle, ACC_out=0x8000, flags_q=0011, one done per op.
- LOAD 0x00FF, then MUL 0x0002 (MULDIV_WAIT=3) -> C15 high 3 consecutive cycles, op_ready low 4 cycles, ACC_out=0x01FE, flags_q=0000.
- LOAD 0x0010, then DIV 0x0000 -> C16 high 3 cycles, ACC_out=0xFFFF, flags_q=0100.
- ACC=0x1234, op_code=14 -> no strobe, ACC_out=0x1234, flags unchanged, done and err_illegal high the same single cycle.
- DIV accepted, rst_n=0 in its 2nd EXEC cycle -> next cycle IDLE, C16=0, ACC_out=0000, no done. op_valid held during a busy op is accepted only after DONE->IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator execute controller: opcodes, flag
// layout, FSM encoding and the ALU strobe vector layout.
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_CLR  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_NOT  = 4'd10;
    localparam logic [3:0] OP_LOAD = 4'd11;

    // Flag register layout {ZF,CF,OF,SF}
    localparam int ZF = 3;
    localparam int CF = 2;
    localparam int OF = 1;
    localparam int SF = 0;

    localparam logic [3:0] FLAGS_RST = 4'b1000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit positions inside the 10-bit strobe vector (C8..C21 in port order)
    localparam int STB_W   = 10;
    localparam int STB_CLR = 0;
    localparam int STB_ADD = 1;
    localparam int STB_SUB = 2;
    localparam int STB_MUL = 3;
    localparam int STB_DIV = 4;
    localparam int STB_SHL = 5;
    localparam int STB_SHR = 6;
    localparam int STB_AND = 7;
    localparam int STB_OR  = 8;
    localparam int STB_NOT = 9;

    // Flags for a LOAD, which bypasses the ALU: only zero and sign are meaningful.
    function automatic logic [3:0] load_flags(input logic [15:0] value);
        logic [3:0] f;
        f     = 4'b0000;
        f[ZF] = (value == 16'h0000);
        f[CF] = 1'b0;
        f[OF] = 1'b0;
        f[SF] = value[15];
        return f;
    endfunction

endpackage

// File: rtl/acc_op_decode.sv
// Combinational opcode decode: one-hot ALU strobe vector plus the
// classification bits the sequencer needs (long op, load bypass, illegal).
module acc_op_decode
    import alu_pkg::*;
(
    input  logic [3:0]       op_code,
    output logic [STB_W-1:0] strobes,
    output logic             is_muldiv,
    output logic             is_load,
    output logic             is_illegal
);

    always_comb begin
        strobes    = '0;
        is_muldiv  = 1'b0;
        is_load    = 1'b0;
        is_illegal = 1'b0;
        case (op_code)
            OP_NOP:  ;
            OP_CLR:  strobes[STB_CLR] = 1'b1;
            OP_ADD:  strobes[STB_ADD] = 1'b1;
            OP_SUB:  strobes[STB_SUB] = 1'b1;
            OP_MUL: begin
                strobes[STB_MUL] = 1'b1;
                is_muldiv        = 1'b1;
            end
            OP_DIV: begin
                strobes[STB_DIV] = 1'b1;
                is_muldiv        = 1'b1;
            end
            OP_SHL:  strobes[STB_SHL] = 1'b1;
            OP_SHR:  strobes[STB_SHR] = 1'b1;
            OP_AND:  strobes[STB_AND] = 1'b1;
            OP_OR:   strobes[STB_OR]  = 1'b1;
            OP_NOT:  strobes[STB_NOT] = 1'b1;
            OP_LOAD: is_load = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/acc_exec_unit.sv
// Execute controller owning ACC and the flag register: accepts one op per
// handshake, holds one ALU strobe for the op's latency, then captures the result.
module acc_exec_unit
    import alu_pkg::*;
#(
    parameter logic [3:0] MULDIV_WAIT = 4'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_code,
    input  logic [15:0] op_operand,
    output logic        C8,
    output logic        C9,
    output logic        C13,
    output logic        C15,
    output logic        C16,
    output logic        C17,
    output logic        C18,
    output logic        C19,
    output logic        C20,
    output logic        C21,
    output logic [15:0] ACC_out,
    output logic [15:0] BR_out,
    input  logic [15:0] ALU_in,
    input  logic [3:0]  ALUflags_in,
    output logic [3:0]  flags_q,
    output logic        done,
    output logic        err_illegal,
    output logic [1:0]  dbg_state
);

    logic [1:0]       state;
    logic [3:0]       wait_cnt;
    logic [STB_W-1:0] strobe_q;
    logic             load_q;
    logic             illegal_q;

    logic [STB_W-1:0] dec_strobes;
    logic             dec_muldiv;
    logic             dec_load;
    logic             dec_illegal;

    acc_op_decode u_decode (
        .op_code    (op_code),
        .strobes    (dec_strobes),
        .is_muldiv  (dec_muldiv),
        .is_load    (dec_load),
        .is_illegal (dec_illegal)
    );

    // Handshake: a transfer happens on any rising edge where op_valid and
    // op_ready are both high. op_ready is high only in IDLE; op_valid seen
    // while busy is ignored and the producer keeps op_code/op_operand stable.
    assign op_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            strobe_q  <= '0;
            load_q    <= 1'b0;
            illegal_q <= 1'b0;
            ACC_out   <= 16'h0000;
            BR_out    <= 16'h0000;
            flags_q   <= FLAGS_RST;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        BR_out    <= op_operand;
                        strobe_q  <= dec_strobes;
                        load_q    <= dec_load;
                        illegal_q <= dec_illegal;
                        wait_cnt  <= dec_muldiv ? MULDIV_WAIT : 4'd1;
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (wait_cnt == 4'd1) begin
                        // LOAD bypasses the ALU; illegal ops leave state untouched.
                        if (load_q) begin
                            ACC_out <= BR_out;
                            flags_q <= load_flags(BR_out);
                        end else if (!illegal_q) begin
                            ACC_out <= ALU_in;
                            flags_q <= ALUflags_in;
                        end
                        strobe_q <= '0;
                        state    <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign done        = (state == ST_DONE);
    assign err_illegal = done & illegal_q;
    assign dbg_state   = state;

    assign C8  = strobe_q[STB_CLR];
    assign C9  = strobe_q[STB_ADD];
    assign C13 = strobe_q[STB_SUB];
    assign C15 = strobe_q[STB_MUL];
    assign C16 = strobe_q[STB_DIV];
    assign C17 = strobe_q[STB_SHL];
    assign C18 = strobe_q[STB_SHR];
    assign C19 = strobe_q[STB_AND];
    assign C20 = strobe_q[STB_OR];
    assign C21 = strobe_q[STB_NOT];

endmodule

// File: tb/tb_acc_exec_unit.sv
// Randomized scoreboard bench for acc_exec_unit with a behavioural ALU and
// an opcode-level reference model of ACC/flags.
module tb_acc_exec_unit;

    localparam int MW = 3;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic [15:0] op_operand;
    logic        C8, C9, C13, C15, C16, C17, C18, C19, C20, C21;
    logic [15:0] ACC_out;
    logic [15:0] BR_out;
    logic [15:0] ALU_in;
    logic [3:0]  ALUflags_in;
    logic [3:0]  flags_q;
    logic        done;
    logic        err_illegal;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    // Expected entry: {acc[15:0], flags[3:0], err, strobes[9:0], n[3:0]}
    logic [34:0] exp_q[$];

    logic [15:0] m_acc;
    logic [3:0]  m_flags;

    acc_exec_unit #(.MULDIV_WAIT(4'(MW))) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .op_operand  (op_operand),
        .C8          (C8),
        .C9          (C9),
        .C13         (C13),
        .C15         (C15),
        .C16         (C16),
        .C17         (C17),
        .C18         (C18),
        .C19         (C19),
        .C20         (C20),
        .C21         (C21),
        .ACC_out     (ACC_out),
        .BR_out      (BR_out),
        .ALU_in      (ALU_in),
        .ALUflags_in (ALUflags_in),
        .flags_q     (flags_q),
        .done        (done),
        .err_illegal (err_illegal),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural ALU ----------------
    // Returns {flags{ZF,CF,OF,SF}, result} for an opcode applied to acc/br.
    function automatic logic [19:0] alu_calc(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [16:0] s;
        logic [31:0] p;
        logic        c;
        logic        o;
        r = a; c = 1'b0; o = 1'b0;
        case (op)
            4'd1: r = 16'h0000;
            4'd2: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
                        o = (a[15] == b[15]) && (r[15] != a[15]); end
            4'd3: begin r = a - b; c = (a < b); o = (a[15] != b[15]) && (r[15] != a[15]); end
            4'd4: begin p = a * b; r = p[15:0]; c = |p[31:16]; o = c; end
            4'd5: begin
                if (b == 16'h0000) return {4'b0100, 16'hFFFF};
                r = a / b;
            end
            4'd6: begin c = a[15]; r = a << 1; end
            4'd7: begin c = a[0];  r = a >> 1; end
            4'd8: r = a & b;
            4'd9: r = a | b;
            4'd10: r = ~a;
            default: r = a;
        endcase
        return {(r == 16'h0000), c, o, r[15], r};
    endfunction

    logic [9:0] stb;
    assign stb = {C21, C20, C19, C18, C17, C16, C15, C13, C9, C8};

    function automatic logic [3:0] stb_to_op(input logic [9:0] s);
        for (int i = 0; i < 10; i++)
            if (s[i]) return 4'(i + 1);
        return 4'd0;
    endfunction

    always_comb begin
        logic [19:0] r;
        r           = alu_calc(stb_to_op(stb), ACC_out, BR_out);
        ALU_in      = r[15:0];
        ALUflags_in = r[19:16];
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + driver ----------------
    task automatic model_push(input logic [3:0] code, input logic [15:0] opnd);
        logic [19:0] r;
        logic [9:0]  es;
        logic [3:0]  n;
        logic        err;
        es  = (code >= 4'd1 && code <= 4'd10) ? (10'd1 << (code - 4'd1)) : 10'd0;
        n   = (code == 4'd4 || code == 4'd5) ? 4'(MW) : 4'd1;
        err = (code >= 4'd12);
        if (code == 4'd11) begin
            m_acc   = opnd;
            m_flags = {(opnd == 16'h0000), 1'b0, 1'b0, opnd[15]};
        end else if (!err) begin
            r       = alu_calc(code, m_acc, opnd);
            m_acc   = r[15:0];
            m_flags = r[19:16];
        end
        exp_q.push_back({m_acc, m_flags, err, es, n});
    endtask

    task automatic send_op(input logic [3:0] code, input logic [15:0] opnd);
        int budget;
        op_valid   = 1'b1;
        op_code    = code;
        op_operand = opnd;
        budget     = 0;
        @(negedge clk);
        while (!op_ready && budget < 64) begin
            budget++;
            @(negedge clk);
        end
        if (!op_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=busy required=ready at %0t", $time);
            op_valid = 1'b0;
            return;
        end
        model_push(code, opnd);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            budget++;
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_acc"},   32'(ACC_out), 32'h0);
        chk({tag, "_br"},    32'(BR_out), 32'h0);
        chk({tag, "_flags"}, 32'(flags_q), 32'h8);
        chk({tag, "_stb"},   32'(stb), 32'h0);
        chk({tag, "_ready"}, 32'(op_ready), 32'h1);
        chk({tag, "_done"},  32'(done), 32'h0);
        chk({tag, "_err"},   32'(err_illegal), 32'h0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [9:0]  seen;
        int          stb_cnt;
        int          busy_cnt;
        logic [34:0] e;
        seen = '0; stb_cnt = 0; busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = '0; stb_cnt = 0; busy_cnt = 0;
            end else begin
                if (stb != 10'd0) begin
                    chk("strobe_onehot", 32'($countones(stb)), 32'd1);
                    seen |= stb;
                    stb_cnt++;
                end
                if (!op_ready) busy_cnt++;
                if (err_illegal && !done) chk("err_without_done", 32'(err_illegal), 32'd0);
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("acc",         32'(ACC_out), 32'(e[34:19]));
                        chk("flags",       32'(flags_q), 32'(e[18:15]));
                        chk("err_illegal", 32'(err_illegal), 32'(e[14]));
                        chk("strobe_set",  32'(seen), 32'(e[13:4]));
                        chk("strobe_len",  32'(stb_cnt), (e[13:4] != 10'd0) ? 32'(e[3:0]) : 32'd0);
                        chk("busy_len",    32'(busy_cnt), 32'(e[3:0]) + 32'd1);
                    end
                    seen = '0; stb_cnt = 0; busy_cnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        op_valid   = 1'b0;
        op_code    = 4'd0;
        op_operand = 16'h0000;
        m_acc      = 16'h0000;
        m_flags    = 4'b1000;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        send_op(4'd11, 16'h7FFF);
        send_op(4'd2,  16'h0001);
        drain();
        chk("add_ovf_acc",   32'(ACC_out), 32'h8000);
        chk("add_ovf_flags", 32'(flags_q), 32'h3);

        send_op(4'd11, 16'h00FF);
        send_op(4'd4,  16'h0002);
        drain();
        chk("mul_acc",   32'(ACC_out), 32'h01FE);
        chk("mul_flags", 32'(flags_q), 32'h0);

        send_op(4'd11, 16'h0010);
        send_op(4'd5,  16'h0000);
        drain();
        chk("div0_acc",   32'(ACC_out), 32'hFFFF);
        chk("div0_flags", 32'(flags_q), 32'h4);

        send_op(4'd11, 16'h1234);
        send_op(4'd14, 16'h5555);
        drain();
        chk("illegal_acc",   32'(ACC_out), 32'h1234);
        chk("illegal_flags", 32'(flags_q), 32'h0);

        // Reset during the second EXEC cycle of a DIV discards the op.
        send_op(4'd5, 16'h0003);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        m_acc   = 16'h0000;
        m_flags = 4'b1000;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("midexec_reset");
        repeat (4) @(negedge clk);
        chk("midexec_no_done_acc", 32'(ACC_out), 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 200; i++) begin
            logic [3:0]  c;
            logic [15:0] v;
            c = 4'($urandom_range(0, 15));
            v = 16'($urandom);
            if ($urandom_range(0, 7) == 0) v = 16'h0000;
            send_op(c, v);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
